// File: rtl/cnu_minsum_serial_if.sv
// ---------------------------------------------------------------------------
// cnu_minsum_serial_if
// Handshake bundle for the serial min-sum check node unit.
//   in_valid / in_ready / in_data   : variable-to-check messages, one per beat
//                                     in_data = {hard bit, sign, magnitude}
//   out_valid / out_ready / out_data: check-to-variable messages, one per beat
//                                     out_data = {sign, magnitude}
//   out_idx  : position of the current output beat within its row
//   out_last : marks the final beat of a row
//   p_bit    : parity of the row's hard decisions, constant across the row
// The slave modport is the check node; the master modport is the PE side.
// ---------------------------------------------------------------------------
interface cnu_minsum_serial_if #(
    parameter int DEGREE = 6,
    parameter int MAG_W  = 4
);
    localparam int IDX_W = $clog2(DEGREE);

    logic             in_valid;
    logic             in_ready;
    logic [MAG_W+1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [MAG_W:0]   out_data;
    logic [IDX_W-1:0] out_idx;
    logic             out_last;
    logic             p_bit;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_idx, out_last, p_bit
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_idx, out_last, p_bit
    );
endinterface

// File: rtl/cnu_minsum_serial.sv
// ---------------------------------------------------------------------------
// cnu_minsum_serial
// Serial-I/O offset min-sum check node unit. A row of DEGREE messages is
// collected one per beat while min1/min2/argmin, the sign XOR and the
// hard-decision parity are tracked. When the row closes, the results move
// into an output bank that streams DEGREE check-to-variable messages back,
// so the collector is immediately free for the next row.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset, discards partial and pending rows
//   bus : slave side of cnu_minsum_serial_if (see that file for signals)
// ---------------------------------------------------------------------------
module cnu_minsum_serial #(
    parameter int DEGREE = 6,
    parameter int MAG_W  = 4,
    parameter int OFFSET = 0
) (
    input  logic               clk,
    input  logic               rst,
    cnu_minsum_serial_if.slave bus
);
    localparam int               IDX_W    = $clog2(DEGREE);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEGREE - 1);
    localparam logic [MAG_W-1:0] OFF      = MAG_W'(OFFSET);

    typedef enum logic {
        BANK_EMPTY,
        BANK_FULL
    } bank_state_t;

    // Collector state
    logic [IDX_W-1:0]  cnt;
    logic [MAG_W-1:0]  min1, min2;
    logic [IDX_W-1:0]  idx1;
    logic [DEGREE-1:0] signs;
    logic              sxor, par;

    // Output bank state
    bank_state_t       bank_state;
    logic [IDX_W-1:0]  out_pos;
    logic [MAG_W-1:0]  b_min1, b_min2;
    logic [IDX_W-1:0]  b_idx1;
    logic [DEGREE-1:0] b_signs;
    logic              b_sxor, b_par;

    logic [MAG_W-1:0]  in_mag;
    logic              in_sign, in_hard;
    logic              accept_in, out_hs, last_out, row_close;

    logic [MAG_W-1:0]  base_min1, base_min2;
    logic              base_sxor, base_par;
    logic [MAG_W-1:0]  nxt_min1, nxt_min2;
    logic [IDX_W-1:0]  nxt_idx1;
    logic              nxt_sxor, nxt_par;
    logic [DEGREE-1:0] nxt_signs;

    logic [MAG_W-1:0]  sel_mag, out_mag;

    assign in_mag  = bus.in_data[MAG_W-1:0];
    assign in_sign = bus.in_data[MAG_W];
    assign in_hard = bus.in_data[MAG_W+1];

    assign out_hs    = (bank_state == BANK_FULL) && bus.out_ready;
    assign last_out  = out_hs && (out_pos == LAST_IDX);

    // The closing beat may only be taken when the bank is free now or is
    // handing over its final beat in this same cycle.
    assign bus.in_ready = (cnt != LAST_IDX) || (bank_state == BANK_EMPTY) || last_out;
    assign accept_in    = bus.in_valid && bus.in_ready;
    assign row_close    = accept_in && (cnt == LAST_IDX);

    // Next collector values for the beat on in_data. Beat 0 starts from the
    // neutral values instead of whatever the previous row left behind. The
    // strict compares keep the first occurrence of a tied minimum as argmin.
    // Signs are shifted in so that bit 0 holds beat 0 once the row is full.
    always_comb begin
        base_min1 = (cnt == '0) ? '1   : min1;
        base_min2 = (cnt == '0) ? '1   : min2;
        base_sxor = (cnt == '0) ? 1'b0 : sxor;
        base_par  = (cnt == '0) ? 1'b0 : par;
        nxt_min1  = base_min1;
        nxt_min2  = base_min2;
        nxt_idx1  = (cnt == '0) ? '0 : idx1;
        if (in_mag < base_min1) begin
            nxt_min2 = base_min1;
            nxt_min1 = in_mag;
            nxt_idx1 = cnt;
        end else if (in_mag < base_min2) begin
            nxt_min2 = in_mag;
        end
        nxt_sxor  = base_sxor ^ in_sign;
        nxt_par   = base_par ^ in_hard;
        nxt_signs = {in_sign, signs[DEGREE-1:1]};
    end

    // Collector registers advance on every accepted input beat; idle cycles
    // leave them untouched so a row may arrive with gaps.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            min1  <= '1;
            min2  <= '1;
            idx1  <= '0;
            signs <= '0;
            sxor  <= 1'b0;
            par   <= 1'b0;
        end else if (accept_in) begin
            min1  <= nxt_min1;
            min2  <= nxt_min2;
            idx1  <= nxt_idx1;
            signs <= nxt_signs;
            sxor  <= nxt_sxor;
            par   <= nxt_par;
            cnt   <= (cnt == LAST_IDX) ? '0 : cnt + 1'b1;
        end
    end

    // Output bank: loaded when a row closes, then walks out_pos through the
    // row one consumed beat at a time. A close that coincides with the final
    // handshake reloads the bank directly, so out_valid never dips.
    always_ff @(posedge clk) begin
        if (rst) begin
            bank_state <= BANK_EMPTY;
            out_pos    <= '0;
            b_min1     <= '0;
            b_min2     <= '0;
            b_idx1     <= '0;
            b_signs    <= '0;
            b_sxor     <= 1'b0;
            b_par      <= 1'b0;
        end else if (row_close) begin
            bank_state <= BANK_FULL;
            out_pos    <= '0;
            b_min1     <= nxt_min1;
            b_min2     <= nxt_min2;
            b_idx1     <= nxt_idx1;
            b_signs    <= nxt_signs;
            b_sxor     <= nxt_sxor;
            b_par      <= nxt_par;
        end else if (out_hs) begin
            if (out_pos == LAST_IDX) begin
                bank_state <= BANK_EMPTY;
                out_pos    <= '0;
            end else begin
                out_pos <= out_pos + 1'b1;
            end
        end
    end

    // The argmin position receives min2, every other position min1; the
    // offset subtraction clamps at zero. Output sign excludes the position's
    // own sign by XOR-ing it back out of the row total.
    always_comb begin
        sel_mag = (out_pos == b_idx1) ? b_min2 : b_min1;
        out_mag = (sel_mag > OFF) ? sel_mag - OFF : '0;
    end

    assign bus.out_valid = (bank_state == BANK_FULL);
    assign bus.out_data  = {b_sxor ^ b_signs[out_pos], out_mag};
    assign bus.out_idx   = out_pos;
    assign bus.out_last  = (bank_state == BANK_FULL) && (out_pos == LAST_IDX);
    assign bus.p_bit     = b_par;
endmodule

// File: doc/cnu_minsum_serial.md
Name: cnu_minsum_serial

Overview:
Parametrised, serial-I/O check node unit for the LDPC decoder, implementing offset min-sum. It is the successor of the fixed 6-input, LUT-based CNU. It accepts DEGREE variable-to-check messages one per cycle from the PE blocks, tracks min1/min2/argmin, the sign XOR and the parity XOR, and then streams DEGREE check-to-variable messages back one per cycle. A ping-pong split between the collector and the output bank lets row n+1 be collected while row n is emitted, giving one message per cycle sustained.

Parameters:
DEGREE, 6, check node degree (messages per row); must be >= 2
MAG_W, 4, magnitude width of each message
OFFSET, 0, offset subtracted from output magnitudes, saturating at 0; must be < 2^MAG_W
IDX_W, $clog2(DEGREE), width of the position counter and the argmin index (derived, not overridden)

Ports:
clk  input  1  rising-edge clock, single clock domain
rst  input  1  synchronous, active-high reset
in_valid  input  1  in_data is valid this cycle
in_ready  output  1  block accepts in_data this cycle
in_data  input  MAG_W+2  [MAG_W+1]=hard decision, [MAG_W]=sign, [MAG_W-1:0]=magnitude
out_valid  output  1  out_data is valid this cycle
out_ready  input  1  downstream accepts out_data this cycle
out_data  output  MAG_W+1  [MAG_W]=sign, [MAG_W-1:0]=magnitude
out_idx  output  IDX_W  position (0..DEGREE-1) of the current out_data within the row
out_last  output  1  high on the beat with out_idx==DEGREE-1
p_bit  output  1  XOR of the row's hard-decision bits; held constant on every beat of the row

Behaviour:
- Handshakes: input beat accepted when in_valid&&in_ready; output beat consumed when out_valid&&out_ready. out_data, out_idx, out_last and p_bit stay stable while out_valid&&!out_ready.
- Collector state:
  - position counter cnt, 0..DEGREE-1
  - min1, min2, idx1
  - sign shift register, DEGREE bits
  - sxor, par
- Per accepted beat with magnitude m at position cnt (update rules):
  - if m < min1: min2 <= min1, min1 <= m, idx1 <= cnt
  - else if m < min2: min2 <= m
  - sxor ^= sign, par ^= hard bit
  - cnt increments; on DEGREE-1 it wraps to 0
  - For the first beat of a row (cnt==0), the updates use min1=min2=all-ones and sxor=par=0 as the starting values, not the previous row's state.
- Tie rule: equal to min1 does not replace it, so idx1 is the first occurrence and min2 equals min1. Equal to min2 leaves min2 unchanged, which gives the same value.
- in_ready:
  - high when cnt < DEGREE-1
  - when cnt == DEGREE-1, high only if the output bank is empty or its last beat is consumed this cycle
- Row close: accepting the beat at cnt==DEGREE-1 loads the output bank with the final min1/min2/idx1/sxor/par and the sign bits (including the current beat's). The collector resets, so the next cycle can accept beat 0 of the next row.
- Latency: out_valid rises the cycle after the last input beat is accepted. Beats are emitted in order, out_idx 0..DEGREE-1.
- Output beat i:
  - magnitude = sat0((i==idx1 ? min2 : min1) - OFFSET)
  - sign = sxor ^ sign_i
- Bank release: after the out_last handshake, out_valid drops unless a new row closes in that same cycle. In that case out_valid stays high with out_idx=0 of the new row (no bubble).
- Reset:
  - out_valid=0, out_data=0, out_idx=0, out_last=0, p_bit=0
  - cnt=0, in_ready=1
  - A partial row in the collector and any unsent bank contents are discarded.
  - rst has priority over any handshake in the same cycle.
- in_valid may toggle within a row. Idle cycles do not reset the collector.

Test Plan:
- Basic row (DEGREE=6, MAG_W=4, OFFSET=0):
  - input: mags 9,2,7,4,15,6; signs 1,0,0,0,0,0; hard bits 1,1,0,1,0,0; out_ready=1
  - required: out mags 2,4,2,2,2,2; out signs 0,1,1,1,1,1; p_bit=1
  - required: first out_valid 1 cycle after the 6th input; out_last only on idx 5
- Tie:
  - input: mags 5,3,7,3,9,12
  - required: idx1=1; all outputs magnitude 3 (out_idx 1 gets min2=3)
- Offset (OFFSET=1):
  - input: basic row stimulus
  - required: mags 1,3,1,1,1,1
  - input: mags 0,0,1,1,1,1
  - required: all outputs magnitude 0 (saturation)
- Backpressure:
  - stimulus: out_ready=0 after row A closes; row B presented continuously
  - required: B beats 0..4 accepted; in_ready=0 at B beat 5; out_data held
  - then: raise out_ready; B beat 5 accepted in the same cycle as A's out_last; next cycle out_valid=1 with out_idx=0 of row B
- Streaming:
  - stimulus: 4 back-to-back rows with in_valid=out_ready=1
  - required: 24 outputs in 24 consecutive cycles after the first row's latency; no bubbles; every row matches the golden min-sum model
- Reset mid-operation:
  - stimulus: rst after 3 beats of a row while a bank is emitting beat 2
  - required: next cycle out_valid=0, in_ready=1, p_bit=0
  - required: a following fresh row gives correct results with no contamination from the discarded data
